// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the load/store path in front of the data BRAM:
//   - access size encodings (SZ_B / SZ_H / SZ_W / SZ_ILL)
//   - LSU state enum (IDLE / WAIT / RESP)
//   - BYTES_PER_WORD
//   - is_misaligned(): trap check for a size/offset pair
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Halfwords need an even offset, words need offset 0, size 11 never works.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_bram_port_if.sv
// -----------------------------------------------------------------------------
// lsu_bram_port_if
// Bundles the execute-side request, writeback-side response and BRAM port B
// signals of the load/store unit.
//   slave  : view of the LSU itself (takes requests, drives the BRAM)
//   master : view of the environment (execute/writeback stages and the BRAM)
// -----------------------------------------------------------------------------
interface lsu_bram_port_if #(
  parameter int ADDR_W = 32
);
  // request from execute
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // response to writeback
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // BRAM port B
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/lsu_bram_port_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for the LSU.
//   Store side: req_size/req_off/req_wdata -> st_we (byte enables), st_din
//               (data replicated across all lanes so any lane can be written)
//   Check:      misalign flag for the incoming request
//   Load side:  ld_dout/ld_size/ld_off/ld_unsigned -> ld_data (lane extracted
//               and sign- or zero-extended)
// -----------------------------------------------------------------------------
module lsu_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]                req_size,
  input  logic [1:0]                req_off,
  input  logic [31:0]               req_wdata,
  output logic [BYTES_PER_WORD-1:0] st_we,
  output logic [31:0]               st_din,
  output logic                      misalign,
  input  logic [31:0]               ld_dout,
  input  logic [1:0]                ld_size,
  input  logic [1:0]                ld_off,
  input  logic                      ld_unsigned,
  output logic [31:0]               ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  assign misalign = is_misaligned(req_size, req_off);

  assign ld_byte = ld_dout[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_dout[{ld_off[1], 4'b0000} +: 16];
  assign sext    = ~ld_unsigned;

  // Store lane steering: byte enables follow the offset, data is replicated.
  always_comb begin
    st_we  = 4'b0000;
    st_din = 32'h0000_0000;
    case (req_size)
      SZ_B: begin
        st_we  = 4'b0001 << req_off;
        st_din = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        st_we  = 4'b0011 << req_off;
        st_din = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        st_we  = 4'b1111;
        st_din = req_wdata;
      end
      default: begin
        st_we  = 4'b0000;
        st_din = 32'h0000_0000;
      end
    endcase
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_byte[7] & sext}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_half[15] & sext}}, ld_half};
      SZ_W:    ld_data = ld_dout;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_bram_port.sv
// -----------------------------------------------------------------------------
// lsu_bram_port
// Single-outstanding load/store unit in front of BRAM port B.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_bram_port_if.slave (req_* from execute, rsp_* to
//                writeback, mem_* to/from the BRAM)
// Misaligned/illegal requests never touch the BRAM and answer with rsp_err.
// Stores answer one cycle after accept; loads wait BRAM_LATENCY cycles in WAIT
// and answer BRAM_LATENCY+1 cycles after accept.
// -----------------------------------------------------------------------------
module lsu_bram_port
  import riscv_mem_pkg::*;
#(
  parameter int BRAM_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_bram_port_if.slave bus
);

  localparam logic [1:0] LAT_LAST = 2'(BRAM_LATENCY - 1);

  lsu_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        ready_s;
  logic        accept;
  logic        misalign;
  logic [3:0]  st_we;
  logic [31:0] st_din;
  logic [31:0] ld_data;

  // Gating with rst_n keeps the BRAM port quiet while reset is held.
  assign ready_s = rst_n && (state_q == IDLE);
  assign accept  = bus.req_valid && ready_s;

  lsu_lane_align u_align (
    .req_size    (bus.req_size),
    .req_off     (bus.req_addr[1:0]),
    .req_wdata   (bus.req_wdata),
    .st_we       (st_we),
    .st_din      (st_din),
    .misalign    (misalign),
    .ld_dout     (bus.mem_dout),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  // State, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-register-value logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end else if (bus.req_we) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = 32'h0000_0000;
          end else begin
            // Remember how to pick the lane once the BRAM data arrives.
            state_d = WAIT;
            cnt_d   = 2'd0;
            off_d   = bus.req_addr[1:0];
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            err_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          cnt_d   = 2'd0;
          rdata_d = ld_data;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs: BRAM port is only active in the accept cycle of a legal access.
  always_comb begin
    bus.req_ready = ready_s;
    bus.mem_en    = accept && !misalign;
    if (accept && !misalign && bus.req_we) begin
      bus.mem_we = st_we;
    end else begin
      bus.mem_we = 4'b0000;
    end
    bus.mem_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    bus.mem_din   = st_din;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_lsu_bram_port.sv
// -----------------------------------------------------------------------------
// tb_lsu_bram_port
// Two LSU instances (BRAM_LATENCY 1 and 2), each with a behavioural BRAM.
// Expected values come from a byte-array memory model and arithmetic
// extension rules.
// -----------------------------------------------------------------------------
module tb_lsu_bram_port;

  localparam int ADDR_W = 32;
  localparam int LAT [2] = '{1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic        rst_n_v        [2];
  logic        req_valid_v    [2];
  logic        req_we_v       [2];
  logic [1:0]  req_size_v     [2];
  logic        req_unsigned_v [2];
  logic [31:0] req_addr_v     [2];
  logic [31:0] req_wdata_v    [2];
  logic        rsp_ready_v    [2];

  // observed
  wire         req_ready_o [2];
  wire         rsp_valid_o [2];
  wire [31:0]  rsp_rdata_o [2];
  wire         rsp_err_o   [2];
  wire         mem_en_o    [2];
  wire [3:0]   mem_we_o    [2];
  wire [31:0]  mem_addr_o  [2];
  wire [31:0]  mem_din_o   [2];

  // behavioural BRAMs and reference byte memory
  logic [31:0] bram    [2][64];
  logic [31:0] rd1     [2];
  logic [31:0] rd2     [2];
  logic [7:0]  ref_mem [2][256];

  int n_checks = 0;
  int n_fail   = 0;

  lsu_bram_port_if #(.ADDR_W(ADDR_W)) bus0 ();
  lsu_bram_port_if #(.ADDR_W(ADDR_W)) bus1 ();

  lsu_bram_port #(.BRAM_LATENCY(1), .ADDR_W(ADDR_W)) dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .bus(bus0.slave));
  lsu_bram_port #(.BRAM_LATENCY(2), .ADDR_W(ADDR_W)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .bus(bus1.slave));

  assign bus0.req_valid    = req_valid_v[0];
  assign bus0.req_we       = req_we_v[0];
  assign bus0.req_size     = req_size_v[0];
  assign bus0.req_unsigned = req_unsigned_v[0];
  assign bus0.req_addr     = req_addr_v[0];
  assign bus0.req_wdata    = req_wdata_v[0];
  assign bus0.rsp_ready    = rsp_ready_v[0];
  assign bus0.mem_dout     = rd1[0];
  assign req_ready_o[0] = bus0.req_ready;
  assign rsp_valid_o[0] = bus0.rsp_valid;
  assign rsp_rdata_o[0] = bus0.rsp_rdata;
  assign rsp_err_o[0]   = bus0.rsp_err;
  assign mem_en_o[0]    = bus0.mem_en;
  assign mem_we_o[0]    = bus0.mem_we;
  assign mem_addr_o[0]  = bus0.mem_addr;
  assign mem_din_o[0]   = bus0.mem_din;

  assign bus1.req_valid    = req_valid_v[1];
  assign bus1.req_we       = req_we_v[1];
  assign bus1.req_size     = req_size_v[1];
  assign bus1.req_unsigned = req_unsigned_v[1];
  assign bus1.req_addr     = req_addr_v[1];
  assign bus1.req_wdata    = req_wdata_v[1];
  assign bus1.rsp_ready    = rsp_ready_v[1];
  assign bus1.mem_dout     = rd2[1];
  assign req_ready_o[1] = bus1.req_ready;
  assign rsp_valid_o[1] = bus1.rsp_valid;
  assign rsp_rdata_o[1] = bus1.rsp_rdata;
  assign rsp_err_o[1]   = bus1.rsp_err;
  assign mem_en_o[1]    = bus1.mem_en;
  assign mem_we_o[1]    = bus1.mem_we;
  assign mem_addr_o[1]  = bus1.mem_addr;
  assign mem_din_o[1]   = bus1.mem_din;

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] din,
                                             input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  // BRAM model: registered read, optional second output register
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en_o[d]) begin
        if (mem_we_o[d] != 4'b0000)
          bram[d][mem_addr_o[d][7:2]] <= merge_word(bram[d][mem_addr_o[d][7:2]], mem_din_o[d], mem_we_o[d]);
        rd1[d] <= bram[d][mem_addr_o[d][7:2]];
      end
      rd2[d] <= rd1[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: assemble little-endian bytes, then extend arithmetically.
  function automatic logic [31:0] ref_load(input int d, input logic [7:0] a, input int nbytes,
                                           input logic uns);
    longint unsigned v;
    longint unsigned full;
    v = 0;
    for (int i = 0; i < nbytes; i++)
      v = v | (longint'(ref_mem[d][a + 8'(i)]) << (8 * i));
    full = longint'(1) << (8 * nbytes);
    if (!uns && (v >= full / 2)) v = v - full;
    return v[31:0];
  endfunction

  task automatic do_txn(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output logic [31:0] got);
    int          nbytes;
    int          cyc;
    int          exp_lat;
    logic [1:0]  off;
    logic        err;
    logic [3:0]  exp_we;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    off    = addr[1:0];
    nbytes = (size == 2'b11) ? 0 : (1 << size);
    err    = (nbytes == 0) ? 1'b1 : ((int'(off) % nbytes) != 0);
    exp_we = (!err && we) ? (4'((1 << nbytes) - 1) << off) : 4'b0000;
    exp_din = 32'h0;
    if (!err && we)
      for (int i = 0; i < 4; i++) exp_din[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    exp_rdata = (err || we) ? 32'h0 : ref_load(d, addr[7:0], nbytes, uns);
    exp_lat   = (err || we) ? 1 : LAT[d] + 1;

    @(negedge clk);
    req_we_v[d]       = we;
    req_size_v[d]     = size;
    req_unsigned_v[d] = uns;
    req_addr_v[d]     = addr;
    req_wdata_v[d]    = wdata;
    req_valid_v[d]    = 1'b1;
    rsp_ready_v[d]    = (stall == 0);
    #1;
    check("req_ready", 32'(req_ready_o[d]), 32'd1);
    check("mem_en", 32'(mem_en_o[d]), 32'(!err));
    check("mem_we", 32'(mem_we_o[d]), 32'(exp_we));
    if (!err) check("mem_addr", mem_addr_o[d], {addr[31:2], 2'b00});
    if (!err && we) check("mem_din", mem_din_o[d], exp_din);
    @(posedge clk); #1;
    req_valid_v[d] = 1'b0;
    cyc = 1;
    while (!rsp_valid_o[d] && cyc < 8) begin
      check("wait_ready", 32'(req_ready_o[d]), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("rsp_valid", 32'(rsp_valid_o[d]), 32'd1);
    check("rsp_err", 32'(rsp_err_o[d]), 32'(err));
    check("rsp_rdata", rsp_rdata_o[d], exp_rdata);
    got = rsp_rdata_o[d];
    for (int k = 0; k < stall; k++) begin
      if (k == 1) begin
        req_valid_v[d] = 1'b1;
        #1;
        check("stall_mem_en", 32'(mem_en_o[d]), 32'd0);
      end
      @(posedge clk); #1;
      req_valid_v[d] = 1'b0;
      check("stall_valid", 32'(rsp_valid_o[d]), 32'd1);
      check("stall_rdata", rsp_rdata_o[d], exp_rdata);
      check("stall_err", 32'(rsp_err_o[d]), 32'(err));
      check("stall_ready", 32'(req_ready_o[d]), 32'd0);
    end
    rsp_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    check("done_valid", 32'(rsp_valid_o[d]), 32'd0);
    check("done_ready", 32'(req_ready_o[d]), 32'd1);
    if (!err && we)
      for (int i = 0; i < nbytes; i++) ref_mem[d][addr[7:0] + 8'(i)] = wdata[8*i +: 8];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [1:0]  sz;
    int          r;

    for (int d = 0; d < 2; d++) begin
      rst_n_v[d]        = 1'b0;
      req_valid_v[d]    = 1'b1;
      req_we_v[d]       = 1'b1;
      req_size_v[d]     = 2'b10;
      req_unsigned_v[d] = 1'b0;
      req_addr_v[d]     = 32'h100;
      req_wdata_v[d]    = 32'h0;
      rsp_ready_v[d]    = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_rsp_valid", 32'(rsp_valid_o[d]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata_o[d], 32'd0);
      check("rst_rsp_err", 32'(rsp_err_o[d]), 32'd0);
      check("rst_mem_en", 32'(mem_en_o[d]), 32'd0);
      check("rst_mem_we", 32'(mem_we_o[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_valid_v[d] = 1'b0;
      rst_n_v[d]     = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) check("rst_req_ready", 32'(req_ready_o[d]), 32'd1);

    // fill both memories with known words
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        do_txn(d, 1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * w), $urandom, 0, got);

    // directed sequence on the latency-1 instance
    do_txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, got);
    check("sw_rdata", got, 32'h0);
    do_txn(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h123456A5, 0, got);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, got);
    check("lw_const", got, 32'hA5ADBEEF);
    do_txn(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, got);
    check("lb_const", got, 32'hFFFFFFA5);
    do_txn(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, got);
    check("lbu_const", got, 32'h000000A5);
    do_txn(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, got);
    check("lh_const", got, 32'hFFFFA5AD);
    do_txn(0, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, got);
    check("lhu_const", got, 32'h0000BEEF);
    do_txn(0, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, got);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, got);
    do_txn(0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, got);
    do_txn(0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h11223344, 0, got);
    do_txn(0, 1'b1, 2'b10, 1'b0, 32'h101, 32'h55667788, 0, got);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5, got);
    check("lw_after_trap", got, 32'hA5ADBEEF);

    // latency-2 instance: load timing, then reset during WAIT
    do_txn(1, 1'b1, 2'b10, 1'b0, 32'h140, 32'h12345678, 0, got);
    do_txn(1, 1'b0, 2'b10, 1'b0, 32'h140, 32'h0, 0, got);
    check("lw2_const", got, 32'h12345678);
    @(negedge clk);
    req_we_v[1]    = 1'b0;
    req_size_v[1]  = 2'b10;
    req_addr_v[1]  = 32'h140;
    req_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    req_valid_v[1] = 1'b0;
    check("rw_in_wait", 32'(req_ready_o[1]), 32'd0);
    rst_n_v[1]     = 1'b0;
    req_valid_v[1] = 1'b1;
    #1;
    check("rw_rsp_valid", 32'(rsp_valid_o[1]), 32'd0);
    check("rw_rsp_rdata", rsp_rdata_o[1], 32'd0);
    check("rw_rsp_err", 32'(rsp_err_o[1]), 32'd0);
    check("rw_mem_en", 32'(mem_en_o[1]), 32'd0);
    check("rw_mem_we", 32'(mem_we_o[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid_v[1] = 1'b0;
    rst_n_v[1]     = 1'b1;
    #1;
    check("rw_req_ready", 32'(req_ready_o[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("rw_no_rsp", 32'(rsp_valid_o[1]), 32'd0);
    end

    // randomized traffic on both instances
    for (int n = 0; n < 280; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_txn((n % 3 == 2) ? 1 : 0, ($urandom_range(0, 2) == 0), sz, 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bram_port.md
Name: lsu_bram_port

Overview:
- Load/store unit that sits directly upstream of port B of the dual-port data BRAM.
- Takes one memory request at a time from the execute stage, builds byte write enables and lane-replicated store data, and waits out the BRAM read latency.
- Extracts and sign- or zero-extends load data, then returns a single response to writeback.
- Misaligned and illegal-size accesses are trapped before any BRAM access.

Parameters:
- BRAM_LATENCY, 1, read latency of the attached BRAM in cycles; legal values are 1 and 2.
- ADDR_W, 32, width of the byte address.

Ports:
- clk  in  1  single clock for the block and the BRAM
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback accepts the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal access
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM byte address, word aligned (req_addr with bits [1:0] forced to 0)
- mem_din  out  32  BRAM write data
- mem_dout  in  32  BRAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- Reset outputs: mem_en = 0 and mem_we = 0 while rst_n is low.
- States: IDLE, WAIT, RESP.
- req_ready is 1 only in IDLE. A request is accepted when req_valid && req_ready.
- mem_* outputs are combinational and are driven only in the accept cycle. Everywhere else mem_en = 0 and mem_we = 0.
- Let off = req_addr[1:0].
- Alignment check:
  - error if req_size == 11;
  - error if req_size == 01 and off[0] == 1;
  - error if req_size == 10 and off != 0.
  - On error: mem_en = 0, go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Aligned store, accept cycle: mem_en = 1.
  - mem_we = 0001<<off (byte), 0011<<off (half), 1111 (word).
  - mem_din = byte replicated x4, half replicated x2, or the word unchanged.
  - Next state RESP with rsp_rdata = 0 and rsp_err = 0. Store latency is 1 cycle from accept to rsp_valid.
- Aligned load, accept cycle: mem_en = 1 and mem_we = 0.
  - Register off, req_size and req_unsigned.
  - Go to WAIT and hold for BRAM_LATENCY cycles.
  - On the last WAIT cycle, capture mem_dout into rsp_rdata after extraction, then go to RESP.
  - Load latency is BRAM_LATENCY+1 cycles from accept to rsp_valid.
- Extraction:
  - byte = mem_dout[8*off +: 8];
  - half = mem_dout[16*off[1] +: 16];
  - word passes through unchanged.
  - Sign-extend unless the registered unsigned flag is set.
- RESP: rsp_valid = 1 and rsp_rdata/rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE. A new request is accepted no earlier than the following cycle.
- Backpressure: rsp_ready low for any number of cycles leaves all response outputs stable and req_ready = 0.
- req_* inputs are ignored outside IDLE.
- Reset asserted mid-operation abandons the transaction: no response is produced, and a load in flight is discarded.
- Address wrap: none. mem_addr passes through with its low 2 bits cleared.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_ILL;
  - the lsu state enum (IDLE, WAIT, RESP);
  - the constant BYTES_PER_WORD = 4.
- One combinational sub-module, lsu_lane_align:
  - store side: size + off -> mem_we/mem_din;
  - load side: mem_dout + size + off + unsigned -> extended data;
  - also produces the misalign flag.
- lsu_bram_port itself contains only the FSM, the latency counter and the response registers.

Test Plan:
- Store word 0xDEADBEEF to 0x100 -> in the accept cycle mem_en = 1, mem_we = 1111, mem_addr = 0x100, mem_din = 0xDEADBEEF. rsp_valid is high 1 cycle later with rsp_err = 0 and rsp_rdata = 0.
- Store byte 0xA5 to 0x103, then load word from 0x100, with BRAM_LATENCY = 1 -> store drives mem_we = 1000 and mem_din = 0xA5A5A5A5. The load responds 2 cycles after accept with rsp_rdata = 0xA5ADBEEF.
- From that memory content:
  - LB at 0x103 -> 0xFFFFFFA5;
  - LBU at 0x103 -> 0x000000A5;
  - LH at 0x102 -> 0xFFFFA5AD;
  - LHU at 0x100 -> 0x0000BEEF.
- Misaligned LH at 0x101 / LW at 0x102 / size 11 -> mem_en stays 0 and mem_we stays 0. rsp_valid is high 1 cycle later with rsp_err = 1 and rsp_rdata = 0.
- Load with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready = 0 throughout. A req_valid pulse during the stall is not accepted. Completion happens in the rsp_ready cycle, and IDLE follows in the next cycle.
- Assert rst_n low during WAIT of a load (BRAM_LATENCY = 2) -> outputs go immediately to rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1 after release, and no response appears.
